// File: rtl/dmem_port_arbiter.sv
// Data memory port arbiter: pipeline memory stage vs. one external requester.
// Pipeline has priority; a starvation counter forces the external port through.
module dmem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic [31:0] A,
  output logic [31:0] WD,
  output logic        WE,
  input  logic [31:0] RD
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [3:0]  starve_q, starve_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        force_gnt;
  logic        gnt;

  assign force_gnt = (starve_q == StarveMax);
  // rst is active-low: while asserted nothing may be granted or written
  assign gnt = rst & ext_req & (~MemReqM | force_gnt);

  assign ext_gnt    = gnt;
  assign StallM     = MemReqM & gnt;
  assign ext_rvalid = rvalid_q;
  assign ext_rdata  = rdata_q;
  assign ReadDataM  = RD;

  always_comb begin
    A  = AddrM;
    WD = WDataM;
    WE = rst & MemReqM & MemWriteM;
    if (gnt) begin
      A  = ext_addr;
      WD = ext_wdata;
      WE = ext_we;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!ext_req || gnt) begin
      starve_d = 4'd0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    rvalid_d = gnt & ~ext_we;
    rdata_d  = rdata_q;
    if (gnt && !ext_we) begin
      rdata_d = RD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= 4'd0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      starve_q <= starve_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter with a memory and a
// denied-streak reference model.
module tb_dmem_port_arbiter;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mreq, mwe;
  logic [31:0] maddr, mwd;
  logic        ereq, ewe;
  logic [31:0] eaddr, ewd;
  logic [31:0] rdm, erdata, A, WD, RD;
  logic        stallm, egnt, ervalid, WE;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];

  int checks = 0;
  int errors = 0;

  // reference model state
  int          streak;
  logic        e_gnt, e_stall, e_we, e_rvalid;
  logic [31:0] e_a, e_wd, e_rdm, e_rdata;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst_n),
    .MemReqM(mreq), .MemWriteM(mwe), .AddrM(maddr), .WDataM(mwd),
    .ReadDataM(rdm), .StallM(stallm),
    .ext_req(ereq), .ext_we(ewe), .ext_addr(eaddr), .ext_wdata(ewd),
    .ext_gnt(egnt), .ext_rvalid(ervalid), .ext_rdata(erdata),
    .A(A), .WD(WD), .WE(WE), .RD(RD)
  );

  assign RD = mem[A[7:2]];
  always @(posedge clk) if (WE) mem[A[7:2]] <= WD;

  task automatic set_in(input logic mr, input logic mw,
                        input logic [31:0] ma, input logic [31:0] md,
                        input logic er, input logic ew,
                        input logic [31:0] ea, input logic [31:0] ed);
    @(negedge clk);
    mreq = mr; mwe = mw; maddr = ma; mwd = md;
    ereq = er; ewe = ew; eaddr = ea; ewd = ed;
    #1;
    e_gnt   = rst_n && er && (!mr || streak >= SM);
    e_stall = mr && e_gnt;
    e_we    = rst_n && (e_gnt ? ew : (mr && mw));
    e_a     = e_gnt ? ea : ma;
    e_wd    = e_gnt ? ed : md;
    e_rdm   = ref_mem[e_a[7:2]];
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (e_gnt && !ewe) begin
        e_rvalid = 1'b1;
        e_rdata  = e_rdm;
      end else begin
        e_rvalid = 1'b0;
      end
      if (e_we) ref_mem[e_a[7:2]] = e_wd;
      streak = (!ereq || e_gnt) ? 0 : streak + 1;
    end
    #1;
  endtask

  task automatic idle();
    set_in(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    streak = 0; e_rvalid = 0; e_rdata = 0;
    set_in(1, 1, 32'h44, 32'h55, 1, 1, 32'h8, 32'h9);
    checks++;
    if (egnt !== 1'b0 || stallm !== 1'b0 || WE !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl gnt=%b stall=%b we=%b need 0 0 0", egnt, stallm, WE);
    end
    checks++;
    if (A !== 32'h44 || WD !== 32'h55) begin
      errors++;
      $display("FAIL reset_mux A=%h WD=%h need 44 55", A, WD);
    end
    checks++;
    if (ervalid !== 1'b0 || erdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rsp rvalid=%b rdata=%h need 0 0", ervalid, erdata);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_ext_rw();
    set_in(0, 0, 32'h0, 32'h0, 1, 1, 32'h10, 32'hDEADBEEF);
    checks++;
    if (egnt !== 1'b1 || stallm !== 1'b0 || WE !== 1'b1 || A !== 32'h10 || WD !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL ext_wr gnt=%b stall=%b we=%b A=%h WD=%h need 1 0 1 10 deadbeef",
               egnt, stallm, WE, A, WD);
    end
    tick();
    set_in(0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0);
    checks++;
    if (egnt !== 1'b1 || stallm !== 1'b0 || WE !== 1'b0) begin
      errors++;
      $display("FAIL ext_rd_gnt gnt=%b stall=%b we=%b need 1 0 0", egnt, stallm, WE);
    end
    tick();
    checks++;
    if (ervalid !== 1'b1 || erdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL ext_rd_data rvalid=%b rdata=%h need 1 deadbeef", ervalid, erdata);
    end
    idle();
    checks++;
    if (ervalid !== 1'b0) begin
      errors++;
      $display("FAIL ext_rvalid_pulse rvalid=%b need 0", ervalid);
    end
  endtask

  task automatic test_starve();
    for (int i = 0; i < 15; i++) begin
      set_in(1, 0, 32'h40, 32'h0, 1, 0, 32'h10, 32'h0);
      checks++;
      if (egnt !== e_gnt || egnt !== (i % 5 == 4) || stallm !== e_stall) begin
        errors++;
        $display("FAIL starve cyc=%0d gnt=%b stall=%b need %b %b",
                 i, egnt, stallm, e_gnt, e_stall);
      end
      tick();
      if (i % 5 == 4) begin
        checks++;
        if (ervalid !== 1'b1 || erdata !== e_rdata) begin
          errors++;
          $display("FAIL starve_rd cyc=%0d rvalid=%b rdata=%h need 1 %h",
                   i, ervalid, erdata, e_rdata);
        end
      end
    end
    idle();
  endtask

  task automatic test_collision();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 32'h40, 32'h0, 1, 1, 32'h20, 32'h5678);
      tick();
    end
    set_in(1, 1, 32'h20, 32'h1234, 1, 1, 32'h20, 32'h5678);
    checks++;
    if (egnt !== 1'b1 || stallm !== 1'b1 || WE !== 1'b1 || WD !== 32'h5678) begin
      errors++;
      $display("FAIL coll_ext gnt=%b stall=%b we=%b WD=%h need 1 1 1 5678",
               egnt, stallm, WE, WD);
    end
    tick();
    set_in(1, 1, 32'h20, 32'h1234, 0, 0, 32'h0, 32'h0);
    checks++;
    if (egnt !== 1'b0 || stallm !== 1'b0 || WE !== 1'b1 || WD !== 32'h1234 || A !== 32'h20) begin
      errors++;
      $display("FAIL coll_pipe gnt=%b stall=%b we=%b A=%h WD=%h need 0 0 1 20 1234",
               egnt, stallm, WE, A, WD);
    end
    tick();
    set_in(1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0);
    checks++;
    if (rdm !== 32'h1234 || rdm !== e_rdm) begin
      errors++;
      $display("FAIL coll_read got=%h need 1234", rdm);
    end
    tick();
    idle();
  endtask

  task automatic test_pipe_load();
    mem[12] = 32'hA5A5A5A5;
    ref_mem[12] = 32'hA5A5A5A5;
    set_in(1, 0, 32'h30, 32'h0, 0, 0, 32'h0, 32'h0);
    checks++;
    if (rdm !== 32'hA5A5A5A5 || stallm !== 1'b0 || egnt !== 1'b0 || WE !== 1'b0) begin
      errors++;
      $display("FAIL pipe_load rd=%h stall=%b gnt=%b we=%b need a5a5a5a5 0 0 0",
               rdm, stallm, egnt, WE);
    end
    tick();
    idle();
  endtask

  task automatic test_drop();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 32'h40, 32'h0, 1, 0, 32'h10, 32'h0);
      tick();
    end
    set_in(1, 0, 32'h40, 32'h0, 0, 0, 32'h10, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 32'h40, 32'h0, 1, 0, 32'h10, 32'h0);
      checks++;
      if (egnt !== (i == 4) || egnt !== e_gnt) begin
        errors++;
        $display("FAIL drop cyc=%0d gnt=%b need %b", i, egnt, (i == 4));
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    set_in(0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0);
    tick();
    checks++;
    if (ervalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre rvalid=%b need 1", ervalid);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    streak = 0; e_rvalid = 0; e_rdata = 0;
    checks++;
    if (ervalid !== 1'b0 || erdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_rst rvalid=%b rdata=%h need 0 0", ervalid, erdata);
    end
    set_in(1, 1, 32'h50, 32'h77, 1, 1, 32'h10, 32'h66);
    checks++;
    if (WE !== 1'b0 || stallm !== 1'b0 || egnt !== 1'b0) begin
      errors++;
      $display("FAIL mid_ctl we=%b stall=%b gnt=%b need 0 0 0", WE, stallm, egnt);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_random();
    logic mr, mw, er, ew;
    logic [31:0] ma, md, ea, ed;
    mr = 0; mw = 0; er = 0; ew = 0; ma = 0; md = 0; ea = 0; ed = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(stallm === 1'b1)) begin
        mr = ($urandom_range(0, 3) != 0);
        mw = $urandom_range(0, 1) == 1;
        ma = {24'h0, 6'($urandom_range(0, 15)), 2'b00};
        md = $urandom;
      end
      if (!er || egnt === 1'b1) begin
        er = $urandom_range(0, 1) == 1;
        ew = $urandom_range(0, 1) == 1;
        ea = {24'h0, 6'($urandom_range(0, 15)), 2'b00};
        ed = $urandom;
      end
      set_in(mr, mw, ma, md, er, ew, ea, ed);
      checks++;
      if (egnt !== e_gnt || stallm !== e_stall || WE !== e_we ||
          A !== e_a || rdm !== e_rdm || (e_we && WD !== e_wd)) begin
        errors++;
        $display("FAIL rand_comb i=%0d gnt=%b/%b stall=%b/%b we=%b/%b A=%h/%h rd=%h/%h",
                 i, egnt, e_gnt, stallm, e_stall, WE, e_we, A, e_a, rdm, e_rdm);
      end
      tick();
      checks++;
      if (ervalid !== e_rvalid || erdata !== e_rdata) begin
        errors++;
        $display("FAIL rand_rsp i=%0d rvalid=%b/%b rdata=%h/%h",
                 i, ervalid, e_rvalid, erdata, e_rdata);
      end
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    mreq = 0; mwe = 0; maddr = 0; mwd = 0;
    ereq = 0; ewe = 0; eaddr = 0; ewd = 0;
    rst_n = 1'b0;
    test_reset();
    test_ext_rw();
    test_pipe_load();
    test_starve();
    test_collision();
    test_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
